out_port_ctrl: RTL and testbench
================================

Name: out_port_ctrl

Overview:
Per-output-port controller of the router switch stage; it is the requester/consumer side of the fixed-priority switch arbiter. It forwards input-port requests to an external combinational arbiter (ARB_REQ/ARB_GRT) and takes the one-hot grant. It then holds the output for the granted input until the tail flit passes (wormhole lock). It also tracks downstream buffer credits and drives the crossbar select and input dequeue strobes.

Parameters:
NR, 5, number of input ports / requesters (width of all per-input vectors)
CREDITS, 4, downstream buffer depth; credit counter reset value and maximum

Ports:
CLK  input  1  clock, rising edge
RSTn  input  1  reset, synchronous, active-low
REQ_IN  input  NR  bit i: input i presents a valid flit routed to this output
TAIL_IN  input  NR  bit i: flit presented by input i is a tail (single-flit packet = head+tail)
ARB_REQ  output  NR  request vector to external fixed-priority arbiter
ARB_GRT  input  NR  one-hot (or zero) grant from arbiter, same cycle as ARB_REQ
XSEL  output  NR  one-hot crossbar select, zero when nothing transfers
POP  output  NR  bit i: dequeue flit from input i this cycle (equals XSEL)
FLIT_VLD  output  1  flit driven to downstream link this cycle
CREDIT_IN  input  1  one credit returned by downstream this cycle
CREDIT_CNT  output  $clog2(CREDITS+1)  current credit count
LOCKED  output  1  state == BUSY
CREDIT_ERR  output  1  sticky: credit returned while counter already at CREDITS

Behaviour:
- State register: IDLE / BUSY; owner register: NR-bit one-hot.
- Reset (RSTn low at rising edge): state=IDLE, owner=0, credit=CREDITS, CREDIT_ERR=0.
- While RSTn is low, all combinational outputs are forced 0: ARB_REQ, XSEL, POP, FLIT_VLD.
- send = FLIT_VLD (at most one flit per cycle).
- IDLE:
  - ARB_REQ = REQ_IN if credit>0, else 0.
  - XSEL = POP = ARB_GRT & ARB_REQ; FLIT_VLD = |XSEL.
  - Head transfers in the grant cycle (zero-cycle grant-to-send latency).
  - On send with TAIL_IN[granted]=1: stay IDLE.
  - On send with tail=0: owner <= grant, go BUSY.
  - ARB_GRT bits outside ARB_REQ are ignored.
- BUSY:
  - ARB_REQ = 0; new requests are not arbitrated.
  - send when |(REQ_IN & owner) and credit>0; XSEL = POP = owner when sending, else 0.
  - Send with |(TAIL_IN & owner): go IDLE and clear owner at the edge.
  - Owner gaps (REQ_IN[owner]=0) hold the lock indefinitely.
- Credit counter:
  - send without CREDIT_IN: -1.
  - CREDIT_IN without send: +1.
  - Both in the same cycle: unchanged.
  - CREDIT_IN at CREDITS (no send): saturate and set CREDIT_ERR (sticky until reset).
  - credit=0 blocks all sends; never underflows.
- A returned credit enables a send no earlier than the next cycle (registered count).
- Reset mid-packet: lock dropped, credits restored. Upstream/downstream must be reset in the same cycle.
- LOCKED = (state==BUSY).

Optional Feature:
Macro OUT_PORT_CTRL_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 64), an idle counter and output TIMEOUT_ERR (1 bit, 1-cycle pulse).
  - In BUSY the counter increments every cycle without a send and clears on any send or on leaving BUSY.
  - When it reaches TIMEOUT_CYC-1 with no send, the next edge forces IDLE, clears owner, clears the counter and pulses TIMEOUT_ERR.
  - Reset value 0.
- Undefined: no counter, no TIMEOUT_ERR port; the lock is held until the tail.

Test Plan:
1. Reset then idle, REQ_IN=0 -> CREDIT_CNT=4, LOCKED=0, CREDIT_ERR=0, FLIT_VLD=0.
2. REQ_IN=5'b00110, tail=0, ARB_GRT=5'b00010 -> POP=00010, LOCKED=1 next cycle. Two body flits then a tail from input 1 -> 3 more POPs to 00010 while REQ_IN[2] stays high with no grant. After the tail: IDLE, input 2 granted the following cycle.
3. Single-flit packet from input 3 (REQ_IN[3]=TAIL_IN[3]=1, ARB_GRT=01000) -> one POP, LOCKED stays 0, CREDIT_CNT 4->3.
4. Five-flit packet with no CREDIT_IN -> 4 flits sent, CREDIT_CNT=0, POP=0, ARB_REQ=0. CREDIT_IN pulse -> 5th flit sent one cycle later, count stays 0.
5. Same cycle send + CREDIT_IN at count 2 -> count stays 2. CREDIT_IN at count 4 with no send -> count stays 4, CREDIT_ERR=1 and sticky.
6. RSTn low while BUSY with credit=1 -> next cycle LOCKED=0, CREDIT_CNT=4, outputs 0. With OUT_PORT_CTRL_TIMEOUT_EN and TIMEOUT_CYC=8: owner stalls for 8 cycles -> TIMEOUT_ERR pulses once, LOCKED=0.

Source files
------------

// File: rtl/out_port_ctrl.sv
// out_port_ctrl: per-output-port controller of the router switch stage.
// Forwards input requests to an external fixed-priority arbiter, sends the
// granted head flit in the grant cycle, then holds the output for that input
// (wormhole lock) until its tail flit passes. Tracks downstream credits.
//
// Optional feature macro: OUT_PORT_CTRL_TIMEOUT_EN
//   Adds parameter TIMEOUT_CYC and output TIMEOUT_ERR; a lock that stalls for
//   TIMEOUT_CYC cycles without a send is forcibly released.
//
// Ports:
//   CLK, RSTn    clock (rising edge), synchronous active-low reset
//   REQ_IN       per-input valid flit routed to this output
//   TAIL_IN      per-input tail marker for the presented flit
//   ARB_REQ      request vector to the external arbiter (combinational)
//   ARB_GRT      one-hot grant returned in the same cycle
//   XSEL, POP    one-hot crossbar select / input dequeue strobe (combinational)
//   FLIT_VLD     flit driven downstream this cycle (combinational)
//   CREDIT_IN    one downstream credit returned
//   CREDIT_CNT   current credit count
//   LOCKED       output is locked to an owner input
//   TIMEOUT_ERR  one-cycle pulse on forced lock release (macro only)
//   CREDIT_ERR   sticky credit overflow flag
module out_port_ctrl #(
    parameter int unsigned NR      = 5,
    parameter int unsigned CREDITS = 4
`ifdef OUT_PORT_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
    input  logic                         CLK,
    input  logic                         RSTn,
    input  logic [NR-1:0]                REQ_IN,
    input  logic [NR-1:0]                TAIL_IN,
    output logic [NR-1:0]                ARB_REQ,
    input  logic [NR-1:0]                ARB_GRT,
    output logic [NR-1:0]                XSEL,
    output logic [NR-1:0]                POP,
    output logic                         FLIT_VLD,
    input  logic                         CREDIT_IN,
    output logic [$clog2(CREDITS+1)-1:0] CREDIT_CNT,
    output logic                         LOCKED,
`ifdef OUT_PORT_CTRL_TIMEOUT_EN
    output logic                         TIMEOUT_ERR,
`endif
    output logic                         CREDIT_ERR
);

    localparam int unsigned CW = $clog2(CREDITS+1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NR-1:0]   r_owner;
    logic [NR-1:0]   w_owner_nxt;
    logic [CW-1:0]   r_credit;
    logic            r_credit_err;
    logic            w_has_credit;
    logic            w_send;
    logic            w_tail;
    logic            w_timeout;
    logic [NR-1:0]   w_arb_req;
    logic [NR-1:0]   w_xsel;

    assign w_has_credit = (r_credit != '0);

    // State and owner register
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next-state logic; the owner is captured from the grant of a non-tail head
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_send && !w_tail) begin
                    w_state_nxt = ST_BUSY;
                    w_owner_nxt = w_xsel;
                end
            end
            ST_BUSY: begin
                if ((w_send && w_tail) || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_owner_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = '0;
            end
        endcase
    end

    // Output logic; everything is held at zero while reset is asserted
    always_comb begin
        w_arb_req = '0;
        w_xsel    = '0;
        w_tail    = 1'b0;
        if (RSTn) begin
            case (r_state)
                ST_IDLE: begin
                    // Masking with ARB_REQ drops stray grant bits and blocks
                    // sends when out of credit
                    w_arb_req = w_has_credit ? REQ_IN : '0;
                    w_xsel    = ARB_GRT & w_arb_req;
                    w_tail    = |(TAIL_IN & w_xsel);
                end
                ST_BUSY: begin
                    if (|(REQ_IN & r_owner) && w_has_credit)
                        w_xsel = r_owner;
                    w_tail = |(TAIL_IN & r_owner);
                end
                default: begin
                    w_xsel = '0;
                end
            endcase
        end
    end

    assign w_send     = |w_xsel;
    assign ARB_REQ    = w_arb_req;
    assign XSEL       = w_xsel;
    assign POP        = w_xsel;
    assign FLIT_VLD   = w_send;
    assign LOCKED     = (r_state == ST_BUSY);
    assign CREDIT_CNT = r_credit;
    assign CREDIT_ERR = r_credit_err;

    // Credit counter: a send consumes, CREDIT_IN returns, both cancel out
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_credit     <= CW'(CREDITS);
            r_credit_err <= 1'b0;
        end else if (w_send && !CREDIT_IN) begin
            r_credit <= r_credit - CW'(1);
        end else if (!w_send && CREDIT_IN) begin
            if (r_credit == CW'(CREDITS))
                r_credit_err <= 1'b1;
            else
                r_credit <= r_credit + CW'(1);
        end
    end

`ifdef OUT_PORT_CTRL_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] r_to_cnt;
    logic          r_timeout_err;

    assign w_timeout = (r_state == ST_BUSY) && !w_send &&
                       (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    // Stall counter for a held lock; cleared by any send or by leaving BUSY
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if ((r_state != ST_BUSY) || w_send || w_timeout)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign TIMEOUT_ERR = r_timeout_err;
`else
    assign w_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_out_port_ctrl.sv
// Directed self-checking bench for out_port_ctrl (NR=5, CREDITS=4).
module tb_out_port_ctrl;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic [4:0] REQ_IN, TAIL_IN, ARB_GRT;
    logic [4:0] ARB_REQ, XSEL, POP;
    logic       FLIT_VLD, CREDIT_IN, LOCKED, CREDIT_ERR;
    logic [2:0] CREDIT_CNT;
`ifdef OUT_PORT_CTRL_TIMEOUT_EN
    logic       TIMEOUT_ERR;
`endif

    int n_chk = 0;
    int n_err = 0;

    out_port_ctrl #(
        .NR(5),
        .CREDITS(4)
`ifdef OUT_PORT_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(8)
`endif
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .REQ_IN(REQ_IN), .TAIL_IN(TAIL_IN),
        .ARB_REQ(ARB_REQ), .ARB_GRT(ARB_GRT), .XSEL(XSEL), .POP(POP),
        .FLIT_VLD(FLIT_VLD), .CREDIT_IN(CREDIT_IN), .CREDIT_CNT(CREDIT_CNT),
        .LOCKED(LOCKED),
`ifdef OUT_PORT_CTRL_TIMEOUT_EN
        .TIMEOUT_ERR(TIMEOUT_ERR),
`endif
        .CREDIT_ERR(CREDIT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Apply inputs, then let combinational outputs settle before checks
    task automatic drive(input logic [4:0] req, input logic [4:0] tail,
                         input logic [4:0] grt, input logic cin);
        REQ_IN    = req;
        TAIL_IN   = tail;
        ARB_GRT   = grt;
        CREDIT_IN = cin;
        #1;
    endtask

    task automatic chk_send(input string tag, input logic [4:0] exp_pop);
        chk({tag, "_pop"},  32'(POP),      32'(exp_pop));
        chk({tag, "_xsel"}, 32'(XSEL),     32'(exp_pop));
        chk({tag, "_vld"},  32'(FLIT_VLD), 32'(|exp_pop));
    endtask

    initial begin
        RSTn = 1'b0;
        drive(5'b11111, 5'b00000, 5'b00001, 1'b0);
        // Outputs forced low during reset
        chk("rst_arbreq", 32'(ARB_REQ), 32'd0);
        chk_send("rst", 5'b00000);
        tick();
        tick();
        RSTn = 1'b1;

        // 1: idle after reset
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        chk("idle_cnt", 32'(CREDIT_CNT), 32'd4);
        chk("idle_lock", 32'(LOCKED), 32'd0);
        chk("idle_cerr", 32'(CREDIT_ERR), 32'd0);
        chk_send("idle", 5'b00000);

        // 2: multi-flit packet from input 1 while input 2 waits
        drive(5'b00110, 5'b00000, 5'b00010, 1'b0);
        chk("p2_arbreq", 32'(ARB_REQ), 32'b00110);
        chk_send("p2_head", 5'b00010);
        tick();
        chk("p2_lock", 32'(LOCKED), 32'd1);
        chk("p2_cnt1", 32'(CREDIT_CNT), 32'd3);
        drive(5'b00110, 5'b00000, 5'b00100, 1'b1);
        chk("p2_busy_arbreq", 32'(ARB_REQ), 32'd0);
        chk_send("p2_body1", 5'b00010);
        tick();
        chk("p2_cnt_cancel", 32'(CREDIT_CNT), 32'd3);
        // Owner gap: lock held, nothing sent, input 2 not served
        drive(5'b00100, 5'b00000, 5'b00100, 1'b0);
        chk_send("p2_gap", 5'b00000);
        tick();
        chk("p2_gap_lock", 32'(LOCKED), 32'd1);
        drive(5'b00110, 5'b00000, 5'b00100, 1'b0);
        chk_send("p2_body2", 5'b00010);
        tick();
        chk("p2_cnt2", 32'(CREDIT_CNT), 32'd2);
        drive(5'b00110, 5'b00010, 5'b00100, 1'b0);
        chk_send("p2_tail", 5'b00010);
        tick();
        chk("p2_unlock", 32'(LOCKED), 32'd0);
        chk("p2_cnt3", 32'(CREDIT_CNT), 32'd1);
        drive(5'b00100, 5'b00100, 5'b00100, 1'b1);
        chk_send("p2_in2", 5'b00100);
        tick();
        chk("p2_in2_lock", 32'(LOCKED), 32'd0);
        chk("p2_cnt4", 32'(CREDIT_CNT), 32'd1);
        // Grant outside the request vector is ignored
        drive(5'b00001, 5'b00001, 5'b00010, 1'b1);
        chk_send("stray_grt", 5'b00000);
        tick();
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
        tick();
        tick();
        chk("refill_cnt", 32'(CREDIT_CNT), 32'd4);

        // 3: single-flit packet from input 3
        drive(5'b01000, 5'b01000, 5'b01000, 1'b0);
        chk_send("p3", 5'b01000);
        tick();
        chk("p3_lock", 32'(LOCKED), 32'd0);
        chk("p3_cnt", 32'(CREDIT_CNT), 32'd3);
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
        tick();
        chk("p3_refill", 32'(CREDIT_CNT), 32'd4);

        // 4: five-flit packet from input 0 with credits running out
        for (int i = 0; i < 4; i++) begin
            drive(5'b00001, 5'b00000, 5'b00001, 1'b0);
            chk_send($sformatf("p4_f%0d", i), 5'b00001);
            tick();
            chk($sformatf("p4_cnt%0d", i), 32'(CREDIT_CNT), 32'(3 - i));
        end
        drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
        chk_send("p4_stall", 5'b00000);
        chk("p4_arbreq", 32'(ARB_REQ), 32'd0);
        chk("p4_lock", 32'(LOCKED), 32'd1);
        tick();
        // Returned credit is usable only from the next cycle
        drive(5'b00001, 5'b00001, 5'b00001, 1'b1);
        chk_send("p4_cin_cycle", 5'b00000);
        tick();
        chk("p4_cnt_ret", 32'(CREDIT_CNT), 32'd1);
        drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
        chk_send("p4_tail", 5'b00001);
        tick();
        chk("p4_cnt_end", 32'(CREDIT_CNT), 32'd0);
        chk("p4_unlock", 32'(LOCKED), 32'd0);
        // Idle with zero credit: no requests forwarded
        drive(5'b00010, 5'b00010, 5'b00010, 1'b0);
        chk("p4_idle_arbreq", 32'(ARB_REQ), 32'd0);
        chk_send("p4_idle", 5'b00000);
        tick();
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
        tick();
        tick();
        chk("p5_cnt2", 32'(CREDIT_CNT), 32'd2);

        // 5: simultaneous send + credit, then overflow
        drive(5'b00001, 5'b00001, 5'b00001, 1'b1);
        chk_send("p5_send", 5'b00001);
        tick();
        chk("p5_cnt_same", 32'(CREDIT_CNT), 32'd2);
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
        tick();
        tick();
        chk("p5_cnt_full", 32'(CREDIT_CNT), 32'd4);
        chk("p5_cerr0", 32'(CREDIT_ERR), 32'd0);
        tick();
        chk("p5_cnt_sat", 32'(CREDIT_CNT), 32'd4);
        chk("p5_cerr1", 32'(CREDIT_ERR), 32'd1);
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        tick();
        tick();
        chk("p5_cerr_sticky", 32'(CREDIT_ERR), 32'd1);

        // 6: reset while busy with one credit left
        for (int i = 0; i < 3; i++) begin
            drive(5'b10000, 5'b00000, 5'b10000, 1'b0);
            tick();
        end
        chk("p6_lock", 32'(LOCKED), 32'd1);
        chk("p6_cnt", 32'(CREDIT_CNT), 32'd1);
        RSTn = 1'b0;
        drive(5'b10000, 5'b00000, 5'b10000, 1'b0);
        chk_send("p6_rst", 5'b00000);
        tick();
        RSTn = 1'b1;
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        chk("p6_unlock", 32'(LOCKED), 32'd0);
        chk("p6_cnt_rst", 32'(CREDIT_CNT), 32'd4);
        chk("p6_cerr_rst", 32'(CREDIT_ERR), 32'd0);
        chk_send("p6_after", 5'b00000);

`ifdef OUT_PORT_CTRL_TIMEOUT_EN
        // Owner stalls for 8 cycles: forced release with one error pulse
        drive(5'b00001, 5'b00000, 5'b00001, 1'b0);
        tick();
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk("to_lock_held", 32'(LOCKED), 32'd1);
        chk("to_err_pre", 32'(TIMEOUT_ERR), 32'd0);
        tick();
        chk("to_unlock", 32'(LOCKED), 32'd0);
        chk("to_err_pulse", 32'(TIMEOUT_ERR), 32'd1);
        tick();
        chk("to_err_end", 32'(TIMEOUT_ERR), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
